// File: rtl/clk_div_monitor.sv
// Measures period and high time of a divided clock sampled on clk, and checks lock against N_EXP.
// Define CLK_DIV_MON_DUAL_EDGE_EN to add negedge sampling (half-cycle units, high time checked).
module clk_div_monitor #(
  parameter int N_EXP    = 3,
  parameter int CW       = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic          clk,
  input  logic          arst,
  input  logic          clk_in_i,
  input  logic          clr_i,
  output logic [CW-1:0] period_o,
  output logic [CW-1:0] high_o,
  output logic          meas_valid_o,
  output logic          locked_o,
  output logic          err_o
);

`ifdef CLK_DIV_MON_DUAL_EDGE_EN
  localparam int NS       = 2;
  localparam int EXP_P    = 2 * N_EXP;
  localparam bit CHK_HIGH = 1'b1;
`else
  localparam int NS       = 1;
  localparam int EXP_P    = N_EXP;
  localparam bit CHK_HIGH = 1'b0;
`endif
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam logic [CW-1:0] MAX_V   = '1;
  localparam logic [CW-1:0] EXP_P_V = CW'(EXP_P);
  localparam logic [CW-1:0] N_V     = CW'(N_EXP);
  localparam logic [MW-1:0] LOCK_V  = MW'(LOCK_CNT);

  logic          s1_q, s2_q, prev_q;
  logic [NS-1:0] samp;

  logic [CW-1:0] hi_q, hi_d, lo_q, lo_d;
  logic          armed_q, armed_d;
  logic [MW-1:0] mcnt_q, mcnt_d;
  logic [CW-1:0] period_q, period_d, high_q, high_d;
  logic          mv_q, mv_d, locked_q, locked_d, err_q, err_d;
  logic          prev_v, smp_v;
  logic [CW:0]   sum_v;

`ifdef CLK_DIV_MON_DUAL_EDGE_EN
  logic n0_q, ns1_q, ns2_q;

  always_ff @(negedge clk or negedge arst) begin
    if (!arst) n0_q <= 1'b0;
    else       n0_q <= clk_in_i;
  end

  // The negedge sample is handed to the posedge pipeline as if captured at the following posedge.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      ns1_q <= 1'b0;
      ns2_q <= 1'b0;
    end else begin
      ns1_q <= n0_q;
      ns2_q <= ns1_q;
    end
  end

  assign samp = {s2_q, ns2_q};
`else
  assign samp = s2_q;
`endif

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= clk_in_i;
      s2_q   <= s1_q;
      prev_q <= samp[NS-1];
    end
  end

  // Samples are applied in time order; at most one of them can be a rising edge.
  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    armed_d  = armed_q;
    mcnt_d   = mcnt_q;
    period_d = period_q;
    high_d   = high_q;
    mv_d     = 1'b0;
    locked_d = locked_q;
    err_d    = err_q;
    prev_v   = prev_q;
    smp_v    = 1'b0;
    sum_v    = '0;
    for (int k = 0; k < NS; k++) begin
      smp_v = samp[k];
      if (smp_v && !prev_v) begin
        if (armed_d) begin
          sum_v    = {1'b0, hi_d} + {1'b0, lo_d};
          period_d = sum_v[CW] ? MAX_V : sum_v[CW-1:0];
          high_d   = hi_d;
          mv_d     = 1'b1;
          if (period_d == EXP_P_V && (!CHK_HIGH || high_d == N_V)) begin
            if (mcnt_d != LOCK_V) mcnt_d = mcnt_d + 1'b1;
            locked_d = (mcnt_d == LOCK_V);
          end else begin
            mcnt_d   = '0;
            locked_d = 1'b0;
            err_d    = 1'b1;
          end
        end
        armed_d = 1'b1;
        hi_d    = CW'(1);
        lo_d    = '0;
      end else if (smp_v) begin
        if (hi_d != MAX_V) hi_d = hi_d + 1'b1;
      end else begin
        if (lo_d != MAX_V) lo_d = lo_d + 1'b1;
      end
      // A saturated counter means the input stalled: drop lock and force a fresh arming edge.
      if (hi_d == MAX_V || lo_d == MAX_V) begin
        mcnt_d   = '0;
        locked_d = 1'b0;
        err_d    = 1'b1;
        armed_d  = 1'b0;
      end
      prev_v = smp_v;
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      hi_q     <= '0;
      lo_q     <= '0;
      armed_q  <= 1'b0;
      mcnt_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      mv_q     <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else if (clr_i) begin
      hi_q     <= '0;
      lo_q     <= '0;
      armed_q  <= 1'b0;
      mcnt_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      mv_q     <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      armed_q  <= armed_d;
      mcnt_q   <= mcnt_d;
      period_q <= period_d;
      high_q   <= high_d;
      mv_q     <= mv_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  assign period_o     = period_q;
  assign high_o       = high_q;
  assign meas_valid_o = mv_q;
  assign locked_o     = locked_q;
  assign err_o        = err_q;

endmodule

// File: doc/clk_div_monitor.md
# clk_div_monitor

Measurement-side counterpart to the team's odd/even 50%-duty clock divider. Samples a divided clock `clk_in` with the source clock `clk` and measures each completed period and high time. Checks the period against an expected divide ratio and reports lock. Used in bring-up and self-test to prove a divider output has the right ratio and duty.

## Interface
- `N_EXP`, default 3: expected divide ratio, ≥2.
- `CW`, default 8: measurement counter width.
- `LOCK_CNT`, default 4: consecutive matching periods required to lock, ≥1.

- `clk`  in  1  measurement clock (the divider's source clock).
- `arst`  in  1  reset, asynchronous, active-low.
- `clk_in`  in  1  divided clock under test.
- `clr`  in  1  synchronous clear, active-high.
- `period`  out  CW  last completed period, in units.
- `high`  out  CW  high time of that period, in units.
- `meas_valid`  out  1  one-cycle pulse when `period`/`high` update.
- `locked`  out  1  `LOCK_CNT` consecutive matching periods seen.
- `err`  out  1  sticky: mismatch or timeout since reset/clear.

## Operation
- Unit: half a `clk` cycle with `CLK_DIV_MON_DUAL_EDGE_EN` defined, one `clk` cycle without. `EXP_P` = 2·N_EXP units (dual) or N_EXP units (single).
- Sample stream: `clk_in` is sampled into a 2-stage pipeline clocked on `clk` posedge. In dual mode, a negedge sample is also captured. Each posedge then processes two samples in order: the negedge sample, then the posedge sample. Each sample is one unit.
- Per sample, with `prev` = previous sample value:
  - sample 1 → `hi_cnt`++.
  - sample 0 → `lo_cnt`++.
  - Both counters saturate at 2^CW−1.
- Rising edge (prev 0, sample 1):
  - If armed, capture `period` = hi_cnt+lo_cnt (saturating) and `high` = hi_cnt, then pulse `meas_valid`.
  - If not armed, set armed only; no `meas_valid`.
  - In both cases, restart counting with the current sample as the first high unit (hi_cnt=1, lo_cnt=0).
- Input period must be ≥2 units, so at most one rising edge occurs per `clk`.
- Lock check, on each `meas_valid`:
  - Dual mode: match = (period==EXP_P && high==N_EXP).
  - Single mode: match = (period==EXP_P); high is not checked.
  - On match, `match_cnt`++ saturating at LOCK_CNT. `locked` = (match_cnt==LOCK_CNT).
  - On mismatch, match_cnt←0, `locked`←0, `err`←1.
- Timeout: if hi_cnt or lo_cnt reaches 2^CW−1, then `locked`←0, match_cnt←0, `err`←1, armed←0. The next rising edge re-arms only.
- `clr`: next posedge sets counters, armed, match_cnt, `period`, `high`, `locked` and `err` to 0, and `meas_valid` to 0. `clr` beats a concurrent edge or timeout.
- Reset values: `period`=0, `high`=0, `meas_valid`=0, `locked`=0, `err`=0, armed=0, all counters 0. `arst` mid-measurement discards the partial period.

## Timing
- Sample latency: a posedge sample captured at posedge t reaches edge detection after stage 2 (posedge t+1). `meas_valid`, `period`, `high`, `locked` and `err` are registered and update at posedge t+2.
- A negedge sample between posedges t−1 and t is treated as captured at t.
- `meas_valid` is exactly one cycle wide. `period`/`high` hold until the next `meas_valid` or clear.
- `locked` and `err` update in the same cycle as the `meas_valid` that causes them. Timeout updates appear 2 cycles after the saturating sample.
- `clr` asserted at posedge t takes effect in outputs at t+1. The pipeline still carries 2 stale samples; they are counted but cannot produce `meas_valid` because armed=0.

## Configuration
- `CLK_DIV_MON_DUAL_EDGE_EN` defined:
  - Adds the negedge sampler; unit = half cycle.
  - High time is checked, so odd-N 50% duty (e.g. high 1.5 cycles) is measured exactly.
- Undefined:
  - Posedge sampling only; unit = one cycle; no negedge flops.
  - High time is reported but excluded from the match.

## Test plan
- Dual mode, N_EXP=3, `clk_in` = divide-by-3 at 50% (1.5 cycles high/low) → first rise arms; then `meas_valid` every 3 cycles with period=6, high=3. `locked`=1 with the 4th `meas_valid`; `err`=0.
- Single mode, N_EXP=4, `clk_in` = divide-by-4 at 50% → period=4, high=2, `locked`=1 after 4 valids.
- After lock, switch `clk_in` to divide-by-5 (dual) → next valid shows period=10, high=5; `locked`=0 and `err`=1 in that cycle. After switching back to divide-by-3, 4 valids relock while `err` stays 1.
- Hold `clk_in` low after lock, CW=8 → 255 units later (2 cycles of latency) `locked`=0, `err`=1. The next rise produces no `meas_valid`; the second rise produces one.
- Assert `clr` for 1 cycle mid-period while locked → `period`=`high`=0, `locked`=`err`=0. No `meas_valid` until the second subsequent rising edge.
- Pulse `arst` low mid-period → all outputs 0 immediately. After release, the first rising edge only arms.
